imem_loader: RTL and testbench

Boot-time writer for the processor's 19-bit-wide, 4096-entry instruction memory. It accepts a byte stream over a valid/ready handshake and checks a header and a checksum. It assembles 19-bit instruction words and drives the instruction memory's write port. The CPU is held in reset via cpu_hold until a complete, checksum-valid image has been written.

---
 rtl/imem_loader.sv | 205 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the 19-bit x 4096-entry instruction memory.
// Receives a byte stream (HDR0, HDR1, N x 3 word bytes, checksum) over a
// valid/ready handshake and writes each assembled word into the memory.
// The CPU stays held via cpu_hold until a checksum-valid image has landed.
// Optional feature: define LOADER_TIMEOUT_EN to abort an idle stream after
// TIMEOUT_CYCLES cycles without an accepted byte (err_code 11).
module imem_loader #(
  parameter int ADDR_W         = 12,
  parameter int INSTR_W        = 19,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR0  = 4'd1,
    S_HDR1  = 4'd2,
    S_B0    = 4'd3,
    S_B1    = 4'd4,
    S_B2    = 4'd5,
    S_WRITE = 4'd6,
    S_CSUM  = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
  } state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  count_r;     // number of words minus one
  logic [ADDR_W-1:0]  word_cnt_r;  // index of the word being assembled
  logic [7:0]         csum_r;      // running XOR of every accepted byte
  logic [7:0]         b0_r;
  logic [7:0]         b1_r;
  logic               accept_s;

  // The top byte of a word carries only the upper instruction bits; the
  // remaining pad bits must be zero or the image is rejected.
  function automatic logic pad_ok(input logic [7:0] b);
    return (b[7:INSTR_W-16] == '0);
  endfunction

  assign accept_s = in_valid & in_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_r;
  logic             active_s;

  // States in which the loader is waiting on the byte stream.
  assign active_s = (state_r == S_HDR0) || (state_r == S_HDR1) ||
                    (state_r == S_B0)   || (state_r == S_B1)   ||
                    (state_r == S_B2)   || (state_r == S_CSUM);
`endif

  // Loader FSM: handshake, header/word assembly, memory write and status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'b00;
      count_r    <= '0;
      word_cnt_r <= '0;
      csum_r     <= 8'h00;
      b0_r       <= 8'h00;
      b1_r       <= 8'h00;
`ifdef LOADER_TIMEOUT_EN
      tmo_r      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_r    <= S_HDR0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
            csum_r     <= 8'h00;
            word_cnt_r <= '0;
          end
        end
        S_HDR0: begin
          if (accept_s) begin
            count_r[7:0] <= in_data;
            csum_r       <= csum_r ^ in_data;
            state_r      <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (accept_s) begin
            count_r[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
            csum_r              <= csum_r ^ in_data;
            state_r             <= S_B0;
          end
        end
        S_B0: begin
          if (accept_s) begin
            b0_r    <= in_data;
            csum_r  <= csum_r ^ in_data;
            state_r <= S_B1;
          end
        end
        S_B1: begin
          if (accept_s) begin
            b1_r    <= in_data;
            csum_r  <= csum_r ^ in_data;
            state_r <= S_B2;
          end
        end
        S_B2: begin
          if (accept_s) begin
            csum_r   <= csum_r ^ in_data;
            in_ready <= 1'b0;
            if (pad_ok(in_data)) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt_r;
              imem_wdata <= {in_data[INSTR_W-17:0], b1_r, b0_r};
              state_r    <= S_WRITE;
            end else begin
              state_r  <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'b10;
              busy     <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          in_ready <= 1'b1;
          if (word_cnt_r == count_r) begin
            state_r <= S_CSUM;
          end else begin
            word_cnt_r <= word_cnt_r + ADDR_W'(1);
            state_r    <= S_B0;
          end
        end
        S_CSUM: begin
          if (accept_s) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum_r) begin
              state_r  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_r  <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'b01;
            end
          end
        end
        default: begin
          state_r  <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
`ifdef LOADER_TIMEOUT_EN
      // Idle-stream watchdog; a timeout wins over the case above, which
      // cannot have advanced since no byte was accepted.
      if (active_s) begin
        if (accept_s) begin
          tmo_r <= '0;
        end else if (tmo_r == TMO_LAST) begin
          tmo_r    <= '0;
          state_r  <= S_ERR;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          error    <= 1'b1;
          err_code <= 2'b11;
        end else begin
          tmo_r <= tmo_r + TMO_W'(1);
        end
      end else begin
        tmo_r <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vectors plus randomized
// images, each compared against a stream-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [18:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  imem_loader #(.ADDR_W(12), .INSTR_W(19), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_q[$];
  int         exp_addr[$];
  int         exp_data[$];
  int         obs_addr[$];
  int         obs_data[$];
  logic       exp_done;
  logic [1:0] exp_code;
  int         cyc = 0;
  int         last_acc = -10;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: capture writes, check in_ready is low and the strobe follows the B2 accept.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      check("we_ready_low", int'(in_ready), 0);
      check("we_latency", last_acc, cyc - 1);
      obs_addr.push_back(int'(imem_addr));
      obs_data.push_back(int'(imem_wdata));
    end
    if (rst && in_valid && in_ready) last_acc <= cyc;
    cyc <= cyc + 1;
  end

  function automatic logic [7:0] xor_q();
    logic [7:0] x = 8'h00;
    foreach (tx_q[i]) x ^= tx_q[i];
    return x;
  endfunction

  // Reference model: build an image from the stream rules and its expected effect.
  task automatic build_image(input int n, input int pad_idx, input bit bad_csum);
    logic [11:0] cnt;
    logic [18:0] w;
    logic [7:0]  x;
    cnt = 12'(n - 1);
    tx_q.delete(); exp_addr.delete(); exp_data.delete();
    tx_q.push_back(cnt[7:0]);
    tx_q.push_back({4'($urandom), cnt[11:8]});
    for (int i = 0; i < n; i++) begin
      w = 19'($urandom);
      tx_q.push_back(w[7:0]);
      tx_q.push_back(w[15:8]);
      if (i == pad_idx) begin
        tx_q.push_back({5'($urandom_range(1, 31)), w[18:16]});
        exp_done = 1'b0;
        exp_code = 2'b10;
        return;
      end
      tx_q.push_back({5'b00000, w[18:16]});
      exp_addr.push_back(i);
      exp_data.push_back(int'(w));
    end
    x = xor_q();
    if (bad_csum) begin
      x ^= 8'($urandom_range(1, 255));
      exp_done = 1'b0;
      exp_code = 2'b01;
    end else begin
      exp_done = 1'b1;
      exp_code = 2'b00;
    end
    tx_q.push_back(x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feed tx_q with random in_valid stalls; bounded by a cycle budget.
  task automatic run_stream(input bit stalls);
    int idx = 0;
    int guard = 0;
    int limit;
    logic acc;
    limit = 8 * tx_q.size() + 100;
    while (idx < tx_q.size() && guard < limit) begin
      if (stalls && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = tx_q[idx];
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= limit) check("stream_stuck", idx, tx_q.size());
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, int'(in_ready), 0);
    check({tag, "_we"}, int'(imem_we), 0);
    check({tag, "_addr"}, int'(imem_addr), 0);
    check({tag, "_wdata"}, int'(imem_wdata), 0);
    check({tag, "_hold"}, int'(cpu_hold), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_code"}, int'(err_code), 0);
  endtask

  task automatic run_session(input string tag, input bit stalls);
    int k = 0;
    obs_addr.delete(); obs_data.delete();
    pulse_start();
    check({tag, "_busy_start"}, int'(busy), 1);
    run_stream(stalls);
    while (!done && !error && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done"}, int'(done), int'(exp_done));
    check({tag, "_error"}, int'(error), int'(!exp_done));
    check({tag, "_code"}, int'(err_code), int'(exp_code));
    check({tag, "_hold"}, int'(cpu_hold), int'(!exp_done));
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ready"}, int'(in_ready), 0);
    check({tag, "_nwr"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check({tag, "_waddr"}, obs_addr[i], exp_addr[i]);
      check({tag, "_wdata"}, obs_data[i], exp_data[i]);
    end
  endtask

  task automatic expect_words(input int a0, input int d0);
    exp_addr.delete(); exp_data.delete();
    exp_addr.push_back(a0); exp_data.push_back(d0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Single word, checksum 0x23.
    tx_q = '{8'h00, 8'h00, 8'h34, 8'h12, 8'h05, 8'h23};
    expect_words(0, 32'h51234);
    exp_done = 1'b1; exp_code = 2'b00;
    run_session("single", 1'b0);

    // Two words with stalls, checksum computed from the preceding bytes.
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'h01, 8'h11, 8'h22, 8'h03};
    tx_q.push_back(xor_q());
    expect_words(0, 32'h1BBAA);
    exp_addr.push_back(1); exp_data.push_back(32'h32211);
    exp_done = 1'b1; exp_code = 2'b00;
    run_session("two", 1'b1);

    // Bad checksum: word still written, then a clean rerun.
    tx_q = '{8'h00, 8'h00, 8'h34, 8'h12, 8'h05, 8'h24};
    expect_words(0, 32'h51234);
    exp_done = 1'b0; exp_code = 2'b01;
    run_session("badcs", 1'b1);
    tx_q = '{8'h00, 8'h00, 8'h34, 8'h12, 8'h05, 8'h23};
    expect_words(0, 32'h51234);
    exp_done = 1'b1; exp_code = 2'b00;
    run_session("rerun", 1'b1);

    // Pad bit violation in B2.
    tx_q = '{8'h00, 8'h00, 8'h34, 8'h12, 8'h0D};
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_code = 2'b10;
    run_session("pad", 1'b1);

    // Reset after the B1 accept, then a full load.
    tx_q = '{8'h00, 8'h00, 8'h34, 8'h12};
    pulse_start();
    run_stream(1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    rst = 1'b1;
    build_image(3, -1, 1'b0);
    run_session("postrst", 1'b1);

    // Randomized images.
    for (int s = 0; s < 12; s++) begin
      int n;
      int pad;
      n = $urandom_range(1, 24);
      pad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      build_image(n, pad, ($urandom_range(0, 3) == 0));
      run_session("rand", 1'b1);
    end

    // Largest image: 4096 words, addresses 0..4095.
    build_image(4096, -1, 1'b0);
    run_session("max", 1'b0);

    // Idle stream after HDR0.
    tx_q = '{8'h05};
    pulse_start();
    run_stream(1'b0);
    begin
      int k = 0;
      while (!error && k < 60) begin
        @(posedge clk); #1;
        k++;
      end
`ifdef LOADER_TIMEOUT_EN
      check("tmo_cycles", k, 16);
      check("tmo_code", int'(err_code), 3);
      check("tmo_hold", int'(cpu_hold), 1);
`else
      check("notmo_error", int'(error), 0);
      check("notmo_busy", int'(busy), 1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
